// File: rtl/seg7_bcd_display_pkg.sv
// Shared definitions for the 4-digit seven-segment BCD display: conversion FSM
// encoding, segment patterns and small nibble helpers.
package seg7_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;
  localparam int unsigned REFRESH_CNT_W       = 20;

  localparam int BIN_W = 8;
  localparam int BCD_W = 12;
  localparam int AN_W  = 4;
  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_digits_t;

  // Cathode patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to each BCD nibble before a shift.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nibble);
    if (nibble >= 4'd5) begin
      return nibble + 4'd3;
    end else begin
      return nibble;
    end
  endfunction

endpackage

// File: rtl/seg7_bcd_display_if.sv
// Load/status/drive bundle between the value source and the display block.
interface seg7_bcd_display_if;
  import seg7_pkg::*;

  logic [BIN_W-1:0] DISP_VALUE;
  logic             DISP_LOAD;
  logic             BUSY;
  logic [AN_W-1:0]  AN;
  logic [SEG_W-1:0] SEG;
  logic             DP;

  modport master (
    output DISP_VALUE,
    output DISP_LOAD,
    input  BUSY,
    input  AN,
    input  SEG,
    input  DP
  );

  modport slave (
    input  DISP_VALUE,
    input  DISP_LOAD,
    output BUSY,
    output AN,
    output SEG,
    output DP
  );

endinterface

// File: rtl/seg7_bcd_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: 8 SHIFT cycles plus one DONE
// cycle in which bcd is valid; a start seen in DONE chains straight into SHIFT.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             MCLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      r_state;
  conv_state_e      w_state_nxt;
  logic [BCD_W-1:0] r_scratch;
  logic [BCD_W-1:0] w_scratch_nxt;
  logic [BIN_W-1:0] r_value;
  logic [BIN_W-1:0] w_value_nxt;
  logic [2:0]       r_shift_cnt;
  logic [2:0]       w_shift_cnt_nxt;
  logic [BCD_W-1:0] w_adjusted;

  // State and datapath registers
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_scratch   <= 12'd0;
      r_value     <= 8'd0;
      r_shift_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_scratch   <= w_scratch_nxt;
      r_value     <= w_value_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
    end
  end

  assign w_adjusted = {dabble_adjust(r_scratch[11:8]),
                       dabble_adjust(r_scratch[7:4]),
                       dabble_adjust(r_scratch[3:0])};

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_scratch_nxt   = r_scratch;
    w_value_nxt     = r_value;
    w_shift_cnt_nxt = r_shift_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt     = ST_SHIFT;
          w_scratch_nxt   = 12'd0;
          w_value_nxt     = bin;
          w_shift_cnt_nxt = 3'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_scratch_nxt   = {w_adjusted[10:0], r_value[7]};
        w_value_nxt     = {r_value[6:0], 1'b0};
        w_shift_cnt_nxt = r_shift_cnt + 3'd1;
        if (r_shift_cnt == 3'd7) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt     = ST_SHIFT;
          w_scratch_nxt   = 12'd0;
          w_value_nxt     = bin;
          w_shift_cnt_nxt = 3'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign bcd  = r_scratch;

endmodule

// File: rtl/seg7_bcd_display.sv
// Four-digit multiplexed seven-segment display of an 8-bit value in decimal,
// with leading-zero blanking and queued loads while a conversion runs.
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic              MCLK,
  input  logic              RESET,
  seg7_bcd_display_if.slave bus
);

  localparam logic [REFRESH_CNT_W-1:0] REFRESH_LAST = REFRESH_CNT_W'(REFRESH_DIV - 1);

  logic                     w_busy;
  logic                     w_done;
  logic                     w_start;
  logic [BIN_W-1:0]         w_start_val;
  logic [BCD_W-1:0]         w_bcd;
  logic                     r_pending;
  logic [BIN_W-1:0]         r_pend_val;
  bcd_digits_t              r_disp;
  logic [REFRESH_CNT_W-1:0] r_refresh_cnt;
  logic                     w_scan_tick;
  logic [1:0]               r_digit_idx;
  logic [3:0]               w_nibble;
  logic                     w_blank;
  logic [AN_W-1:0]          w_an_nxt;
  logic [SEG_W-1:0]         w_seg_nxt;
  logic [AN_W-1:0]          r_an;
  logic [SEG_W-1:0]         r_seg;

  // A load arriving in the DONE cycle bypasses the pending register and
  // chains directly, so BUSY never drops between queued conversions.
  assign w_start     = (~w_busy | w_done) & (bus.DISP_LOAD | r_pending);
  assign w_start_val = bus.DISP_LOAD ? bus.DISP_VALUE : r_pend_val;

  bin2bcd_seq u_bin2bcd (
    .MCLK  (MCLK),
    .RESET (RESET),
    .start (w_start),
    .bin   (w_start_val),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Pending load holding register, latest value wins
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_pending  <= 1'b0;
      r_pend_val <= 8'd0;
    end else if (w_start) begin
      r_pending  <= 1'b0;
    end else if (bus.DISP_LOAD && w_busy) begin
      r_pending  <= 1'b1;
      r_pend_val <= bus.DISP_VALUE;
    end
  end

  // Display register, written only with a completed conversion
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_disp <= '{hundreds: 4'd0, tens: 4'd0, ones: 4'd0};
    end else if (w_done) begin
      r_disp <= bcd_digits_t'(w_bcd);
    end
  end

  assign w_scan_tick = (r_refresh_cnt == REFRESH_LAST);

  // Refresh divider and digit scan index
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_refresh_cnt <= 20'd0;
      r_digit_idx   <= 2'd0;
    end else if (w_scan_tick) begin
      r_refresh_cnt <= 20'd0;
      r_digit_idx   <= r_digit_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 20'd1;
    end
  end

  // Digit selection with leading-zero blanking
  always_comb begin
    w_nibble = 4'd0;
    w_blank  = 1'b1;
    case (r_digit_idx)
      2'd0: begin
        w_nibble = r_disp.ones;
        w_blank  = 1'b0;
      end
      2'd1: begin
        w_nibble = r_disp.tens;
        w_blank  = (r_disp.hundreds == 4'd0) && (r_disp.tens == 4'd0);
      end
      2'd2: begin
        w_nibble = r_disp.hundreds;
        w_blank  = (r_disp.hundreds == 4'd0);
      end
      default: begin
        w_nibble = 4'd0;
        w_blank  = 1'b1;
      end
    endcase
  end

  // Anode/cathode drive for the selected digit
  always_comb begin
    w_an_nxt  = 4'b1111;
    w_seg_nxt = SEG_BLANK;
    if (!w_blank) begin
      w_an_nxt  = ~(4'b0001 << r_digit_idx);
      w_seg_nxt = seg_encode(w_nibble);
    end else begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = SEG_BLANK;
    end
  end

  // Registered display outputs
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.BUSY = w_busy;
  assign bus.AN   = r_an;
  assign bus.SEG  = r_seg;
  assign bus.DP   = 1'b1;

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Scoreboard bench for seg7_bcd_display with REFRESH_DIV=4: expected values are
// queued at load time and compared against the scanned digits once shown.
module tb_seg7_bcd_display;

  logic MCLK;
  logic RESET;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] exp_q [$];
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic [6:0] cap_seg  [4];
  bit         cap_seen [4];
  int cap_bad_an, cap_seg_bad, cap_dp_bad, cap_busy, cap_order_bad, cap_run_bad, cap_runs, cap_wraps;

  seg7_bcd_display_if bus ();

  seg7_bcd_display #(.REFRESH_DIV(4)) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] ref_digit(input int v, input int d);
    case (d)
      0:       return 4'(v % 10);
      1:       return 4'((v / 10) % 10);
      2:       return 4'(v / 100);
      default: return 4'd0;
    endcase
  endfunction

  function automatic bit ref_blank(input int v, input int d);
    if (d == 3) return 1'b1;
    if (d == 2) return (v / 100) == 0;
    if (d == 1) return (v / 10) == 0;
    return 1'b0;
  endfunction

  function automatic logic [6:0] ref_seg(input int v, input int d);
    if (ref_blank(v, d)) return 7'b1111111;
    return seg_tab[ref_digit(v, d)];
  endfunction

  function automatic logic [3:0] next_an(input logic [3:0] an);
    case (an)
      4'b1110: return 4'b1101;
      4'b1101: return 4'b1011;
      4'b1011: return 4'b1111;
      4'b1111: return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic do_load(input logic [7:0] v);
    bus.DISP_VALUE = v;
    bus.DISP_LOAD  = 1'b1;
    @(posedge MCLK);
    #1;
    bus.DISP_LOAD  = 1'b0;
  endtask

  task automatic wait_busy_drop(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge MCLK);
      if (bus.BUSY !== 1'b1) break;
      n++;
    end
  endtask

  task automatic apply_reset();
    @(negedge MCLK);
    RESET = 1'b1;
    repeat (2) @(posedge MCLK);
    @(negedge MCLK);
    RESET = 1'b0;
  endtask

  task automatic capture(input int n);
    int         d;
    int         run;
    bit         first_run;
    logic [3:0] last_an;
    for (int k = 0; k < 4; k++) begin
      cap_seen[k] = 1'b0;
      cap_seg[k]  = 7'b1111111;
    end
    cap_bad_an = 0; cap_seg_bad = 0; cap_dp_bad = 0; cap_busy = 0;
    cap_order_bad = 0; cap_run_bad = 0; cap_runs = 0; cap_wraps = 0;
    run = 0; first_run = 1'b1; last_an = 4'b0000;
    for (int i = 0; i < n; i++) begin
      @(negedge MCLK);
      if (bus.DP !== 1'b1) cap_dp_bad++;
      if (bus.BUSY === 1'b1) cap_busy++;
      d = -1;
      case (bus.AN)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b1111: d = -1;
        default: cap_bad_an++;
      endcase
      if (d >= 0) begin
        if (cap_seen[d] && cap_seg[d] !== bus.SEG) cap_seg_bad++;
        cap_seen[d] = 1'b1;
        cap_seg[d]  = bus.SEG;
      end else if (bus.AN === 4'b1111 && bus.SEG !== 7'b1111111) begin
        cap_seg_bad++;
      end
      if (i > 0 && bus.AN !== last_an) begin
        if (!first_run) begin
          cap_runs++;
          if (run != 4) cap_run_bad++;
        end
        first_run = 1'b0;
        if (next_an(last_an) !== bus.AN) cap_order_bad++;
        if (last_an === 4'b1111 && bus.AN === 4'b1110) cap_wraps++;
        run = 1;
      end else begin
        run++;
      end
      last_an = bus.AN;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_v;
    RESET = 1'b1;
    bus.DISP_VALUE = 8'd200;
    bus.DISP_LOAD  = 1'b1;
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    checks++;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    checks++;
    if (bus.AN !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", bus.AN); end
    checks++;
    if (bus.SEG !== 7'b1111111) begin failures++; $display("FAIL reset_seg: got %b want 1111111", bus.SEG); end
    checks++;
    if (bus.DP !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", bus.DP); end
    RESET = 1'b0;
    bus.DISP_LOAD = 1'b0;
    exp_q.push_back(8'd0);
    @(negedge MCLK);
    checks++;
    if (bus.AN !== 4'b1110 || bus.SEG !== 7'b1000000 || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: an=%b seg=%b busy=%b want an=1110 seg=1000000 busy=0", bus.AN, bus.SEG, bus.BUSY);
    end
    capture(16);
    exp_v = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
        failures++;
        $display("FAIL reset_digit%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
      end
    end
  endtask

  task automatic test_value_200();
    logic [7:0] exp_v;
    int         n;
    exp_q.push_back(8'd200);
    do_load(8'd200);
    wait_busy_drop(n);
    checks++;
    if (n != 9) begin failures++; $display("FAIL v200_busy_cycles: got %0d want 9", n); end
    capture(16);
    exp_v = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
        failures++;
        $display("FAIL v200_digit%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
      end
    end
    checks++;
    if (cap_order_bad != 0 || cap_run_bad != 0 || cap_bad_an != 0 || cap_seg_bad != 0) begin
      failures++;
      $display("FAIL v200_scan: order_bad=%0d run_bad=%0d bad_an=%0d seg_bad=%0d want all 0", cap_order_bad, cap_run_bad, cap_bad_an, cap_seg_bad);
    end
  endtask

  task automatic test_single_digit();
    logic [7:0] exp_v;
    int         n;
    for (int k = 0; k < 2; k++) begin
      exp_v = (k == 0) ? 8'd7 : 8'd0;
      exp_q.push_back(exp_v);
      do_load(exp_v);
      wait_busy_drop(n);
      checks++;
      if (n != 9) begin failures++; $display("FAIL single_busy_cycles value=%0d: got %0d want 9", exp_v, n); end
      capture(16);
      exp_v = exp_q.pop_front();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
          failures++;
          $display("FAIL single_digit%0d value=%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, exp_v, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
        end
      end
      checks++;
      if (cap_bad_an != 0 || cap_seg_bad != 0) begin
        failures++;
        $display("FAIL single_scan value=%0d: bad_an=%0d seg_bad=%0d want 0", exp_v, cap_bad_an, cap_seg_bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    int         hi;
    int         n;
    int         any_seen;
    hi = 0;
    exp_q.push_back(8'd255);
    do_load(8'd255);
    repeat (3) begin @(negedge MCLK); if (bus.BUSY === 1'b1) hi++; end
    do_load(8'd9);
    repeat (2) begin @(negedge MCLK); if (bus.BUSY === 1'b1) hi++; end
    exp_q.push_back(8'd42);
    do_load(8'd42);
    repeat (5) begin @(negedge MCLK); if (bus.BUSY === 1'b1) hi++; end
    capture(8);
    hi += cap_busy;
    exp_v = exp_q.pop_front();
    any_seen = 0;
    for (int d = 0; d < 4; d++) begin
      if (cap_seen[d]) begin
        any_seen++;
        checks++;
        if (cap_seg[d] !== ref_seg(exp_v, d)) begin
          failures++;
          $display("FAIL b2b_first_digit%0d: seg=%b want %b", d, cap_seg[d], ref_seg(exp_v, d));
        end
      end
    end
    checks++;
    if (any_seen == 0 || cap_bad_an != 0) begin
      failures++;
      $display("FAIL b2b_first_visible: digits_seen=%0d bad_an=%0d want >0 and 0", any_seen, cap_bad_an);
    end
    wait_busy_drop(n);
    checks++;
    if (hi != 18 || n != 0) begin
      failures++;
      $display("FAIL b2b_busy: high_cycles=%0d extra=%0d want 18 and 0", hi, n);
    end
    capture(16);
    exp_v = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
        failures++;
        $display("FAIL b2b_final_digit%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] exp_v;
    int         n;
    apply_reset();
    exp_q.push_back(8'd0);
    do_load(8'd123);
    repeat (4) @(negedge MCLK);
    RESET = 1'b1;
    @(negedge MCLK);
    checks++;
    if (bus.BUSY !== 1'b0 || bus.AN !== 4'b1111) begin
      failures++;
      $display("FAIL abort_reset: busy=%b an=%b want 0 and 1111", bus.BUSY, bus.AN);
    end
    RESET = 1'b0;
    capture(24);
    exp_v = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
        failures++;
        $display("FAIL abort_hold_digit%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
      end
    end
    exp_q.push_back(8'd123);
    do_load(8'd123);
    wait_busy_drop(n);
    checks++;
    if (n != 9) begin failures++; $display("FAIL abort_reload_busy: got %0d want 9", n); end
    capture(16);
    exp_v = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
        failures++;
        $display("FAIL abort_reload_digit%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
      end
    end
  endtask

  task automatic test_scan_rotation();
    int n;
    apply_reset();
    do_load(8'd200);
    wait_busy_drop(n);
    capture(48);
    checks++;
    if (cap_run_bad != 0 || cap_runs < 10) begin
      failures++;
      $display("FAIL scan_hold: run_bad=%0d runs=%0d want 0 and >=10", cap_run_bad, cap_runs);
    end
    checks++;
    if (cap_order_bad != 0 || cap_wraps < 2) begin
      failures++;
      $display("FAIL scan_order: order_bad=%0d wraps=%0d want 0 and >=2", cap_order_bad, cap_wraps);
    end
    checks++;
    if (cap_dp_bad != 0) begin failures++; $display("FAIL scan_dp: low_samples=%0d want 0", cap_dp_bad); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_v;
    int         n;
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(8'(v));
      do_load(8'(v));
      wait_busy_drop(n);
      checks++;
      if (n != 9) begin failures++; $display("FAIL sweep_busy value=%0d: got %0d want 9", v, n); end
      capture(16);
      exp_v = exp_q.pop_front();
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (cap_seen[d] !== !ref_blank(exp_v, d) || cap_seg[d] !== ref_seg(exp_v, d)) begin
          failures++;
          $display("FAIL sweep_digit%0d value=%0d: seen=%0b seg=%b want seen=%0b seg=%b", d, exp_v, cap_seen[d], cap_seg[d], !ref_blank(exp_v, d), ref_seg(exp_v, d));
        end
      end
      checks++;
      if (cap_bad_an != 0 || cap_seg_bad != 0) begin
        failures++;
        $display("FAIL sweep_scan value=%0d: bad_an=%0d seg_bad=%0d want 0", exp_v, cap_bad_an, cap_seg_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_value_200();
    test_single_digit();
    test_back_to_back();
    test_reset_abort();
    test_scan_rotation();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
